ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Runs the full host-request sequence: clock inhibit, start request, 8 data bits LSB-first, odd parity, stop bit, device ACK check.
- Sits beside the keyboard receive path on the same PS2_CLK/PS2_DAT pins. The top level builds open-drain drivers from the *_oe outputs: pin driven 0 when oe=1, high-Z otherwise.

Parameters:
- INHIBIT_CYCLES, 6000, clock-low hold before the request (120 us at 50 MHz).
- START_HOLD_CYCLES, 50, data-low overlap with clock-low before releasing clock (1 us).
- EDGE_TIMEOUT_CYCLES, 750000, maximum wait for the next device falling edge (15 ms); applies from clock release onward.
- SYNC_STAGES, 2, synchronizer depth on ps2_clk_in/ps2_dat_in; minimum 2.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- cmd_data  in  8  byte to send
- cmd_valid  in  1  request
- cmd_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS2_CLK pin level
- ps2_dat_in  in  1  raw PS2_DAT pin level
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_dat_oe  out  1  1 = pull PS2_DAT low
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at the end of every transfer
- ack_ok  out  1  valid with done: 1 = device ACKed
- err_code  out  2  valid with done: 00 ok, 01 timeout, 10 no-ack

Behaviour:
- All outputs are registered.
- Reset values: cmd_ready=1, busy=0, done=0, ack_ok=0, err_code=00, both oe=0, state IDLE.
- Reset mid-transfer: lines are released on the next edge. No done pulse is issued.
- Input path: SYNC_STAGES flops on each input, then falling-edge detect on the synced clock (prev=1, cur=0).
- Accept: cmd_valid & cmd_ready at edge N.
  - cmd_data is latched into the shift register.
  - Parity is latched as ~^cmd_data (odd parity).
  - At N+1: state INHIBIT, clk_oe=1, cmd_ready=0, busy=1.
- INHIBIT: hold clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ with dat_oe=1 (start bit).
- REQ: hold clk_oe=1 and dat_oe=1 for START_HOLD_CYCLES cycles. Then set clk_oe=0 and go to SEND, with bit_cnt=0 and the timeout counter cleared.
- SEND: on each synced clock falling edge:
  - bit_cnt 0-7: dat_oe = ~shift[0], then shift right.
  - bit_cnt 8: dat_oe = ~parity.
  - bit_cnt 9: dat_oe=0 (stop bit = 1).
  - bit_cnt 10: go to ACK and sample synced data on that edge; a low level means ACK.
  - bit_cnt increments on every edge.
- ACK: wait for synced clk=1 and dat=1, i.e. the line is idle. Then go to IDLE and pulse done with ack_ok and err_code set:
  - ack_ok=1, err_code=00 if ACK was sampled;
  - ack_ok=0, err_code=10 otherwise.
- Timeout:
  - A counter runs in SEND and ACK and clears on every falling edge.
  - When it reaches EDGE_TIMEOUT_CYCLES: both oe=0, go to IDLE, done=1, ack_ok=0, err_code=01.
  - A timeout in ACK while waiting for idle also reports 01.
- cmd_valid while busy is ignored. Nothing is queued, and cmd_data changes after accept have no effect.
- The falling edge that triggers the final bit and the timeout expiry can land in the same cycle. The edge wins and the timeout counter clears.
- Glitch rule: only synced edges count. A clock low pulse shorter than SYNC_STAGES cycles may be missed; this is acceptable, since real devices run 10-16.7 kHz.
- done is high for exactly one cycle. cmd_ready returns to 1 in that same cycle, so back-to-back commands may be accepted on the done edge.

Decomposition:
- Shared package ps2_pkg:
  - state enum {IDLE, INHIBIT, REQ, SEND, ACK};
  - err_code constants ERR_NONE=2'b00, ERR_TIMEOUT=2'b01, ERR_NOACK=2'b10;
  - command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
- One sub-module, ps2_line_sync: a parameterised synchronizer for clk and dat that outputs synced levels plus a clk_fall pulse. The keyboard receive path can reuse it.

Test Plan:
- Bench setup: INHIBIT_CYCLES=20, START_HOLD_CYCLES=4, EDGE_TIMEOUT_CYCLES=200. The device model clocks at a 40-cycle period, samples data on rising edges and drives the ACK.
- Send 0xED, device ACKs:
  - clk_oe high exactly 24 cycles, dat_oe rising 20 cycles after clk_oe;
  - captured bits 1,0,1,1,0,1,1,1, parity=1, stop=1;
  - done pulse with ack_ok=1, err_code=00.
- Send 0xF4, device ACKs: parity 0 observed; done with ack_ok=1.
- Send 0x00, device does not ACK (data stays high): parity 1 observed; done with ack_ok=0, err_code=10.
- Send 0xFF, device stops clocking after bit 3:
  - 200 cycles after the last edge both oe=0;
  - done with err_code=01; cmd_ready=1 in the same cycle.
- Assert reset during SEND after bit 5: both oe=0 and cmd_ready=1 the next cycle, no done pulse. A following 0xED command then completes normally.
- Hold cmd_valid high with 0x11 during a 0xED transfer: only 0xED is sent. 0x11 is accepted on the done edge and its inhibit starts the next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line synchronizer.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        REQ     = 3'd2,
        SEND    = 3'd3,
        ACK     = 3'd4
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data pins and flags falling edges of the synced clock.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] clk_sh_r;
    logic [SYNC_STAGES-1:0] dat_sh_r;
    logic                   clk_prev_r;

    // Shift chains reset to the idle-high line level so no false edge follows reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sh_r   <= {SYNC_STAGES{1'b1}};
            dat_sh_r   <= {SYNC_STAGES{1'b1}};
            clk_prev_r <= 1'b1;
        end else begin
            clk_sh_r   <= {clk_sh_r[SYNC_STAGES-2:0], clk_in};
            dat_sh_r   <= {dat_sh_r[SYNC_STAGES-2:0], dat_in};
            clk_prev_r <= clk_sh_r[SYNC_STAGES-1];
        end
    end

    assign clk_sync = clk_sh_r[SYNC_STAGES-1];
    assign dat_sync = dat_sh_r[SYNC_STAGES-1];
    assign clk_fall = clk_prev_r & ~clk_sh_r[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request, 8 data bits, odd parity,
// stop bit and device ACK check, with an edge timeout from clock release onward.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES      = 6000,
    parameter int START_HOLD_CYCLES   = 50,
    parameter int EDGE_TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic [1:0] err_code
);

    localparam int MAX_CNT = max3(INHIBIT_CYCLES, START_HOLD_CYCLES, EDGE_TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(EDGE_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic clk_sync_s, dat_sync_s, clk_fall_s;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .clk_in   (ps2_clk_in),
        .dat_in   (ps2_dat_in),
        .clk_sync (clk_sync_s),
        .dat_sync (dat_sync_s),
        .clk_fall (clk_fall_s)
    );

    ps2_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic             parity_r, parity_s;
    logic             ack_seen_r, ack_seen_s;
    logic             clk_oe_r, clk_oe_s;
    logic             dat_oe_r, dat_oe_s;
    logic             ready_r, ready_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             ack_ok_r, ack_ok_s;
    logic [1:0]       err_r, err_s;

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            ack_seen_r <= 1'b0;
            clk_oe_r   <= 1'b0;
            dat_oe_r   <= 1'b0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ack_ok_r   <= 1'b0;
            err_r      <= ERR_NONE;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            parity_r   <= parity_s;
            ack_seen_r <= ack_seen_s;
            clk_oe_r   <= clk_oe_s;
            dat_oe_r   <= dat_oe_s;
            ready_r    <= ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            ack_ok_r   <= ack_ok_s;
            err_r      <= err_s;
        end
    end

    // Next-state and next-output logic; a synced falling edge always beats timeout expiry.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        parity_s   = parity_r;
        ack_seen_s = ack_seen_r;
        clk_oe_s   = clk_oe_r;
        dat_oe_s   = dat_oe_r;
        done_s     = 1'b0;
        ack_ok_s   = ack_ok_r;
        err_s      = err_r;
        case (state_r)
            IDLE: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
                if (cmd_valid && ready_r) begin
                    shift_s  = cmd_data;
                    parity_s = ~^cmd_data;
                    cnt_s    = '0;
                    clk_oe_s = 1'b1;
                    state_s  = INHIBIT;
                end else begin
                    cnt_s = '0;
                end
            end
            INHIBIT: begin
                if (cnt_r == INH_LAST) begin
                    cnt_s    = '0;
                    dat_oe_s = 1'b1;
                    state_s  = REQ;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            REQ: begin
                if (cnt_r == HOLD_LAST) begin
                    cnt_s     = '0;
                    clk_oe_s  = 1'b0;
                    bit_cnt_s = 4'd0;
                    state_s   = SEND;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            SEND: begin
                if (clk_fall_s) begin
                    cnt_s     = '0;
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    case (bit_cnt_r)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                            dat_oe_s = ~shift_r[0];
                            shift_s  = {1'b0, shift_r[7:1]};
                        end
                        4'd8:    dat_oe_s = ~parity_r;
                        4'd9:    dat_oe_s = 1'b0;
                        default: begin
                            ack_seen_s = ~dat_sync_s;
                            state_s    = ACK;
                        end
                    endcase
                end else if (cnt_r == TO_LAST) begin
                    clk_oe_s = 1'b0;
                    dat_oe_s = 1'b0;
                    done_s   = 1'b1;
                    ack_ok_s = 1'b0;
                    err_s    = ERR_TIMEOUT;
                    state_s  = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ACK: begin
                if (clk_sync_s && dat_sync_s) begin
                    clk_oe_s = 1'b0;
                    dat_oe_s = 1'b0;
                    done_s   = 1'b1;
                    ack_ok_s = ack_seen_r;
                    err_s    = ack_seen_r ? ERR_NONE : ERR_NOACK;
                    state_s  = IDLE;
                end else if (clk_fall_s) begin
                    cnt_s = '0;
                end else if (cnt_r == TO_LAST) begin
                    clk_oe_s = 1'b0;
                    dat_oe_s = 1'b0;
                    done_s   = 1'b1;
                    ack_ok_s = 1'b0;
                    err_s    = ERR_TIMEOUT;
                    state_s  = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
                state_s  = IDLE;
            end
        endcase
        ready_s = (state_s == IDLE);
        busy_s  = (state_s != IDLE);
    end

    assign cmd_ready  = ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign ack_ok     = ack_ok_r;
    assign err_code   = err_r;
    assign ps2_clk_oe = clk_oe_r;
    assign ps2_dat_oe = dat_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model clocking at a 40-cycle period.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int TB_INH  = 20;
    localparam int TB_HOLD = 4;
    localparam int TB_TO   = 200;
    localparam int TB_SYNC = 2;
    localparam int HALF    = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, done, ack_ok;
    logic [1:0] err_code;

    logic dev_clk     = 1'b1;
    logic dev_dat_low = 1'b0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = ~dev_dat_low & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (TB_INH),
        .START_HOLD_CYCLES   (TB_HOLD),
        .EDGE_TIMEOUT_CYCLES (TB_TO),
        .SYNC_STAGES         (TB_SYNC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .err_code   (err_code)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    int         done_cnt      = 0;
    int         last_done_cyc = 0;
    logic       last_ack      = 1'b0;
    logic [1:0] last_err      = 2'b00;
    logic       last_ready    = 1'b0;
    logic [1:0] last_oe       = 2'b00;
    int         clk_rise_cyc  = 0;
    int         clk_fall_cyc  = 0;
    int         dat_rise_cyc  = 0;
    int         last_fall_cyc = 0;
    logic       prev_clk_oe   = 1'b0;
    logic       prev_dat_oe   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Passive monitor: records done pulses and open-drain enable transitions.
    always @(negedge clock) begin
        if (ps2_clk_oe && !prev_clk_oe) clk_rise_cyc = cyc;
        if (!ps2_clk_oe && prev_clk_oe) clk_fall_cyc = cyc;
        if (ps2_dat_oe && !prev_dat_oe && ps2_clk_oe) dat_rise_cyc = cyc;
        prev_clk_oe = ps2_clk_oe;
        prev_dat_oe = ps2_dat_oe;
        if (done) begin
            done_cnt      = done_cnt + 1;
            last_done_cyc = cyc;
            last_ack      = ack_ok;
            last_err      = err_code;
            last_ready    = cmd_ready;
            last_oe       = {ps2_clk_oe, ps2_dat_oe};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int k;
        k = 0;
        while (!cmd_ready && k < 100) begin
            tick(1);
            k++;
        end
        check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_data  = b;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    // Device: waits for the start bit, clocks n_edges falling edges, samples data on rising edges.
    task automatic dev_frame(input int n_edges, input bit do_ack, output logic [9:0] bits);
        int k;
        bits = '0;
        k    = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && k < 200) begin
            tick(1);
            k++;
        end
        check_eq("start_bit_seen", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd1);
        if (ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) begin
            tick(HALF);
            for (int i = 0; i < n_edges; i++) begin
                if (i == 10 && do_ack) dev_dat_low = 1'b1;
                dev_clk       = 1'b0;
                last_fall_cyc = cyc;
                tick(HALF);
                dev_clk = 1'b1;
                if (i < 10) bits[i] = ps2_dat_in;
                dev_dat_low = 1'b0;
                tick(HALF);
            end
        end
    endtask

    task automatic wait_done(input int base, input int budget);
        int k;
        k = 0;
        while (done_cnt == base && k < budget) begin
            tick(1);
            k++;
        end
        check_eq("done_count", 32'(done_cnt), 32'(base + 1));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        int         base;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        tick(3);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ack_err", 32'({ack_ok, err_code}), 32'd0);
        check_eq("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        reset = 1'b0;
        tick(2);

        // 0xED with ACK
        base = done_cnt;
        send_cmd(CMD_SET_LEDS);
        check_eq("ed_busy", 32'({busy, cmd_ready}), 32'b10);
        dev_frame(11, 1'b1, bits);
        wait_done(base, 100);
        check_eq("ed_clk_oe_len", 32'(clk_fall_cyc - clk_rise_cyc), 32'(TB_INH + TB_HOLD));
        check_eq("ed_dat_oe_delay", 32'(dat_rise_cyc - clk_rise_cyc), 32'(TB_INH));
        check_eq("ed_data", 32'(bits[7:0]), 32'hED);
        check_eq("ed_parity", 32'(bits[8]), 32'd1);
        check_eq("ed_stop", 32'(bits[9]), 32'd1);
        check_eq("ed_ack", 32'({last_ack, last_err}), 32'({1'b1, ERR_NONE}));
        check_eq("ed_ready_at_done", 32'(last_ready), 32'd1);
        tick(5);

        // 0xF4 with ACK
        base = done_cnt;
        send_cmd(CMD_ENABLE);
        dev_frame(11, 1'b1, bits);
        wait_done(base, 100);
        check_eq("f4_data", 32'(bits[7:0]), 32'hF4);
        check_eq("f4_parity", 32'(bits[8]), 32'd0);
        check_eq("f4_ack", 32'({last_ack, last_err}), 32'({1'b1, ERR_NONE}));
        tick(5);

        // 0x00 without ACK
        base = done_cnt;
        send_cmd(8'h00);
        dev_frame(11, 1'b0, bits);
        wait_done(base, 100);
        check_eq("00_data", 32'(bits[7:0]), 32'h00);
        check_eq("00_parity", 32'(bits[8]), 32'd1);
        check_eq("00_noack", 32'({last_ack, last_err}), 32'({1'b0, ERR_NOACK}));
        tick(5);

        // 0xFF, device stops after bit 3: timeout counted from the synced edge
        base = done_cnt;
        send_cmd(CMD_RESET);
        dev_frame(4, 1'b0, bits);
        wait_done(base, 400);
        check_eq("ff_bits", 32'(bits[3:0]), 32'hF);
        check_eq("ff_timeout_lat", 32'(last_done_cyc - last_fall_cyc), 32'(TB_TO + TB_SYNC + 1));
        check_eq("ff_err", 32'({last_ack, last_err}), 32'({1'b0, ERR_TIMEOUT}));
        check_eq("ff_ready_at_done", 32'(last_ready), 32'd1);
        check_eq("ff_oe_at_done", 32'(last_oe), 32'd0);
        tick(5);

        // Reset during INHIBIT and during SEND after bit 5; no done pulse
        base = done_cnt;
        send_cmd(CMD_SET_LEDS);
        tick(5);
        check_eq("inh_clk_oe", 32'(ps2_clk_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("inh_rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check_eq("inh_rst_ready", 32'({cmd_ready, busy}), 32'b10);
        send_cmd(CMD_SET_LEDS);
        dev_frame(6, 1'b0, bits);
        check_eq("mid_bits", 32'(bits[5:0]), 32'h2D);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("mid_rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check_eq("mid_rst_ready", 32'({cmd_ready, busy}), 32'b10);
        tick(300);
        check_eq("mid_rst_no_done", 32'(done_cnt), 32'(base));
        send_cmd(CMD_SET_LEDS);
        dev_frame(11, 1'b1, bits);
        wait_done(base, 100);
        check_eq("post_rst_data", 32'(bits[7:0]), 32'hED);
        check_eq("post_rst_ack", 32'({last_ack, last_err}), 32'({1'b1, ERR_NONE}));
        tick(5);

        // cmd_valid held with new data during a transfer
        base      = done_cnt;
        cmd_data  = CMD_SET_LEDS;
        cmd_valid = 1'b1;
        tick(1);
        cmd_data = 8'h11;
        check_eq("hold_busy", 32'({busy, cmd_ready}), 32'b10);
        dev_frame(11, 1'b1, bits);
        check_eq("hold_first_data", 32'(bits[7:0]), 32'hED);
        check_eq("hold_done_once", 32'(done_cnt), 32'(base + 1));
        check_eq("hold_next_inhibit", 32'(clk_rise_cyc - last_done_cyc), 32'd1);
        cmd_valid = 1'b0;
        dev_frame(11, 1'b1, bits);
        wait_done(base + 1, 100);
        check_eq("hold_second_data", 32'(bits[7:0]), 32'h11);
        check_eq("hold_second_parity", 32'(bits[8]), 32'd1);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
